// File: rtl/ysyx_24080006_mem_arb.sv
// Shares the single memory port between instruction fetch (m0, read-only) and load/store (m1).
// Only one transaction is in flight at a time; the owner is held from acceptance to response handshake.
module ysyx_24080006_mem_arb #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LSU_PRIO = 1
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [AW-1:0]     m0_addr,
   output logic              m0_resp_valid,
   input  logic              m0_resp_ready,
   output logic [DW-1:0]     m0_rdata,
   output logic              m0_err,

   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [AW-1:0]     m1_addr,
   input  logic              m1_we,
   input  logic [DW-1:0]     m1_wdata,
   input  logic [DW/8-1:0]   m1_wstrb,
   output logic              m1_resp_valid,
   input  logic              m1_resp_ready,
   output logic [DW-1:0]     m1_rdata,
   output logic              m1_err,

   output logic              s_req_valid,
   input  logic              s_req_ready,
   output logic [AW-1:0]     s_addr,
   output logic              s_we,
   output logic [DW-1:0]     s_wdata,
   output logic [DW/8-1:0]   s_wstrb,
   input  logic              s_resp_valid,
   output logic              s_resp_ready,
   input  logic [DW-1:0]     s_rdata,
   input  logic              s_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              s_req_valid_q, s_req_valid_d;
   logic [AW-1:0]     s_addr_q, s_addr_d;
   logic              s_we_q, s_we_d;
   logic [DW-1:0]     s_wdata_q, s_wdata_d;
   logic [DW/8-1:0]   s_wstrb_q, s_wstrb_d;

   logic              is_idle, is_resp, any_req, win, owner_resp_ready;

   // Winner is only meaningful in IDLE; on a tie, round-robin favours the master not granted last.
   always_comb begin
      is_idle = (state_q == IDLE);
      is_resp = (state_q == RESP);
      any_req = m0_req_valid | m1_req_valid;
      win     = m1_req_valid;
      if (m0_req_valid && m1_req_valid) begin
         win = (LSU_PRIO != 0) ? 1'b1 : ~last_grant_q;
      end
   end

   assign m0_req_ready     = is_idle & any_req & ~win;
   assign m1_req_ready     = is_idle & any_req & win;
   assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      s_req_valid_d = s_req_valid_q;
      s_addr_d      = s_addr_q;
      s_we_d        = s_we_q;
      s_wdata_d     = s_wdata_q;
      s_wstrb_d     = s_wstrb_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d       = REQ;
               owner_d       = win;
               last_grant_d  = win;
               s_req_valid_d = 1'b1;
               if (win) begin
                  s_addr_d  = m1_addr;
                  s_we_d    = m1_we;
                  s_wdata_d = m1_wdata;
                  s_wstrb_d = m1_wstrb;
               end else begin
                  s_addr_d  = m0_addr;
                  s_we_d    = 1'b0;
                  s_wdata_d = '0;
                  s_wstrb_d = '0;
               end
            end
         end
         REQ: begin
            if (s_req_ready) begin
               state_d       = RESP;
               s_req_valid_d = 1'b0;
            end
         end
         RESP: begin
            if (s_resp_valid && owner_resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d       = IDLE;
            s_req_valid_d = 1'b0;
         end
      endcase
   end

   // Reset drops any in-flight transaction and clears the outgoing request payload.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b0;
         s_req_valid_q <= 1'b0;
         s_addr_q      <= '0;
         s_we_q        <= 1'b0;
         s_wdata_q     <= '0;
         s_wstrb_q     <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         s_req_valid_q <= s_req_valid_d;
         s_addr_q      <= s_addr_d;
         s_we_q        <= s_we_d;
         s_wdata_q     <= s_wdata_d;
         s_wstrb_q     <= s_wstrb_d;
      end
   end

   assign s_req_valid = s_req_valid_q;
   assign s_addr      = s_addr_q;
   assign s_we        = s_we_q;
   assign s_wdata     = s_wdata_q;
   assign s_wstrb     = s_wstrb_q;

   // Response path is a pure pass-through to the owner; the other master sees zeros.
   assign s_resp_ready  = is_resp & owner_resp_ready;
   assign m0_resp_valid = is_resp & ~owner_q & s_resp_valid;
   assign m1_resp_valid = is_resp & owner_q & s_resp_valid;
   assign m0_rdata      = (is_resp && !owner_q) ? s_rdata : '0;
   assign m1_rdata      = (is_resp && owner_q) ? s_rdata : '0;
   assign m0_err        = is_resp & ~owner_q & s_err;
   assign m1_err        = is_resp & owner_q & s_err;

endmodule

// File: tb/tb_ysyx_24080006_mem_arb.sv
// Directed bench for the two-master memory arbiter: a fixed-priority instance driven from a
// cycle table plus reset and round-robin sequences on a second instance sharing the inputs.
module tb_ysyx_24080006_mem_arb;

   localparam logic [31:0] A0 = 32'h8000_0000;
   localparam logic [31:0] A1 = 32'h8000_1000;
   localparam logic [31:0] WD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req_valid, m0_resp_ready, m1_req_valid, m1_resp_ready, m1_we;
   logic [31:0] m0_addr, m1_addr, m1_wdata, s_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_req_ready, s_resp_valid, s_err;

   logic        p_m0_req_ready, p_m0_resp_valid, p_m0_err, p_m1_req_ready, p_m1_resp_valid, p_m1_err;
   logic        p_s_req_valid, p_s_we, p_s_resp_ready;
   logic [31:0] p_m0_rdata, p_m1_rdata, p_s_addr, p_s_wdata;
   logic [3:0]  p_s_wstrb;

   logic        r_m0_req_ready, r_m0_resp_valid, r_m0_err, r_m1_req_ready, r_m1_resp_valid, r_m1_err;
   logic        r_s_req_valid, r_s_we, r_s_resp_ready;
   logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
   logic [3:0]  r_s_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_24080006_mem_arb #(.AW(32), .DW(32), .LSU_PRIO(1)) dut_prio (
      .clock(clk), .reset(reset),
      .m0_req_valid(m0_req_valid), .m0_req_ready(p_m0_req_ready), .m0_addr(m0_addr),
      .m0_resp_valid(p_m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(p_m0_rdata), .m0_err(p_m0_err),
      .m1_req_valid(m1_req_valid), .m1_req_ready(p_m1_req_ready), .m1_addr(m1_addr), .m1_we(m1_we),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_resp_valid(p_m1_resp_valid), .m1_resp_ready(m1_resp_ready),
      .m1_rdata(p_m1_rdata), .m1_err(p_m1_err),
      .s_req_valid(p_s_req_valid), .s_req_ready(s_req_ready), .s_addr(p_s_addr), .s_we(p_s_we),
      .s_wdata(p_s_wdata), .s_wstrb(p_s_wstrb), .s_resp_valid(s_resp_valid), .s_resp_ready(p_s_resp_ready),
      .s_rdata(s_rdata), .s_err(s_err)
   );

   ysyx_24080006_mem_arb #(.AW(32), .DW(32), .LSU_PRIO(0)) dut_rr (
      .clock(clk), .reset(reset),
      .m0_req_valid(m0_req_valid), .m0_req_ready(r_m0_req_ready), .m0_addr(m0_addr),
      .m0_resp_valid(r_m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(r_m0_rdata), .m0_err(r_m0_err),
      .m1_req_valid(m1_req_valid), .m1_req_ready(r_m1_req_ready), .m1_addr(m1_addr), .m1_we(m1_we),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_resp_valid(r_m1_resp_valid), .m1_resp_ready(m1_resp_ready),
      .m1_rdata(r_m1_rdata), .m1_err(r_m1_err),
      .s_req_valid(r_s_req_valid), .s_req_ready(s_req_ready), .s_addr(r_s_addr), .s_we(r_s_we),
      .s_wdata(r_s_wdata), .s_wstrb(r_s_wstrb), .s_resp_valid(s_resp_valid), .s_resp_ready(r_s_resp_ready),
      .s_rdata(s_rdata), .s_err(s_err)
   );

   typedef struct {
      logic        rst, m0v, m1v, sqr, srv, m0rr, m1rr;
      logic [31:0] rdata;
      logic        serr;
      logic        e_m0rdy, e_m1rdy, e_sqv;
      logic [31:0] e_addr;
      logic        e_we, e_srr, e_m0rv, e_m1rv;
      logic [31:0] e_m0rd, e_m1rd;
      logic        e_m0err, e_m1err;
   } vec_t;

   vec_t vecs[28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic m0v, input logic m1v, input logic sqr,
                        input logic srv, input logic m0rr, input logic m1rr,
                        input logic [31:0] rd, input logic se);
      reset         = rst;
      m0_req_valid  = m0v;
      m1_req_valid  = m1v;
      s_req_ready   = sqr;
      s_resp_valid  = srv;
      m0_resp_ready = m0rr;
      m1_resp_ready = m1rr;
      s_rdata       = rd;
      s_err         = se;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      m0_addr  = A0;
      m1_addr  = A1;
      m1_we    = 1'b1;
      m1_wdata = WD;
      m1_wstrb = 4'hF;
      drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      repeat (2) next_cycle();

      // rst m0v m1v sqr srv m0rr m1rr rdata serr | m0rdy m1rdy sqv addr we srr m0rv m1rv m0rd m1rd m0err m1err
      vecs[0]  = '{1,0,0,0,0,0,0,32'h0,0,     0,0,0,32'h0,0,0,0,0,32'h0,32'h0,0,0};
      vecs[1]  = '{0,1,0,0,0,0,0,32'h0,0,     1,0,0,32'h0,0,0,0,0,32'h0,32'h0,0,0};
      vecs[2]  = '{0,0,0,1,1,1,0,32'hBAD,0,   0,0,1,A0,0,0,0,0,32'h0,32'h0,0,0};
      vecs[3]  = '{0,0,0,0,1,1,0,32'h413,0,   0,0,0,A0,0,1,1,0,32'h413,32'h0,0,0};
      vecs[4]  = '{0,0,1,0,0,0,0,32'h0,0,     0,1,0,A0,0,0,0,0,32'h0,32'h0,0,0};
      for (int i = 5; i <= 9; i++)
         vecs[i] = '{0,0,0,0,0,0,0,32'h0,0,   0,0,1,A1,1,0,0,0,32'h0,32'h0,0,0};
      vecs[10] = '{0,0,0,1,0,0,0,32'h0,0,     0,0,1,A1,1,0,0,0,32'h0,32'h0,0,0};
      for (int i = 11; i <= 13; i++)
         vecs[i] = '{0,0,0,0,1,1,0,32'h0,1,   0,0,0,A1,1,0,0,1,32'h0,32'h0,0,1};
      vecs[14] = '{0,0,0,0,1,0,1,32'h0,1,     0,0,0,A1,1,1,0,1,32'h0,32'h0,0,1};
      for (int k = 0; k < 3; k++) begin
         vecs[15+3*k] = '{0,1,1,0,0,0,0,32'h0,0, 0,1,0,A1,1,0,0,0,32'h0,32'h0,0,0};
         vecs[16+3*k] = '{0,1,0,1,0,0,0,32'h0,0, 0,0,1,A1,1,0,0,0,32'h0,32'h0,0,0};
         vecs[17+3*k] = '{0,1,0,0,1,0,1,32'h55+k,0, 0,0,0,A1,1,1,0,1,32'h0,32'h55+k,0,0};
      end
      vecs[24] = '{0,1,0,0,0,0,0,32'h0,0,     1,0,0,A1,1,0,0,0,32'h0,32'h0,0,0};
      vecs[25] = '{0,0,0,1,0,0,0,32'h0,0,     0,0,1,A0,0,0,0,0,32'h0,32'h0,0,0};
      vecs[26] = '{0,0,0,0,1,1,0,32'h88,0,    0,0,0,A0,0,1,1,0,32'h88,32'h0,0,0};
      vecs[27] = '{0,0,0,0,1,1,1,32'h99,1,    0,0,0,A0,0,0,0,0,32'h0,32'h0,0,0};

      for (int i = 0; i < 28; i++) begin
         drive(vecs[i].rst, vecs[i].m0v, vecs[i].m1v, vecs[i].sqr, vecs[i].srv,
               vecs[i].m0rr, vecs[i].m1rr, vecs[i].rdata, vecs[i].serr);
         #2;
         chk($sformatf("v%0d m0_req_ready", i), {31'b0, p_m0_req_ready}, {31'b0, vecs[i].e_m0rdy});
         chk($sformatf("v%0d m1_req_ready", i), {31'b0, p_m1_req_ready}, {31'b0, vecs[i].e_m1rdy});
         chk($sformatf("v%0d s_req_valid", i), {31'b0, p_s_req_valid}, {31'b0, vecs[i].e_sqv});
         chk($sformatf("v%0d s_addr", i), p_s_addr, vecs[i].e_addr);
         chk($sformatf("v%0d s_we", i), {31'b0, p_s_we}, {31'b0, vecs[i].e_we});
         chk($sformatf("v%0d s_wdata", i), p_s_wdata, vecs[i].e_we ? WD : 32'h0);
         chk($sformatf("v%0d s_wstrb", i), {28'b0, p_s_wstrb}, vecs[i].e_we ? 32'hF : 32'h0);
         chk($sformatf("v%0d s_resp_ready", i), {31'b0, p_s_resp_ready}, {31'b0, vecs[i].e_srr});
         chk($sformatf("v%0d m0_resp_valid", i), {31'b0, p_m0_resp_valid}, {31'b0, vecs[i].e_m0rv});
         chk($sformatf("v%0d m1_resp_valid", i), {31'b0, p_m1_resp_valid}, {31'b0, vecs[i].e_m1rv});
         chk($sformatf("v%0d m0_rdata", i), p_m0_rdata, vecs[i].e_m0rd);
         chk($sformatf("v%0d m1_rdata", i), p_m1_rdata, vecs[i].e_m1rd);
         chk($sformatf("v%0d m0_err", i), {31'b0, p_m0_err}, {31'b0, vecs[i].e_m0err});
         chk($sformatf("v%0d m1_err", i), {31'b0, p_m1_err}, {31'b0, vecs[i].e_m1err});
         next_cycle();
      end

      // Reset while the LSU transaction waits in RESP with a response pending.
      drive(0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
      next_cycle();
      drive(0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
      next_cycle();
      drive(1, 0, 0, 0, 1, 0, 0, 32'h1234, 1);
      next_cycle();
      drive(0, 0, 0, 0, 1, 1, 1, 32'h1234, 1);
      #2;
      chk("rst s_req_valid", {31'b0, p_s_req_valid}, 32'h0);
      chk("rst s_addr", p_s_addr, 32'h0);
      chk("rst s_we", {31'b0, p_s_we}, 32'h0);
      chk("rst s_wdata", p_s_wdata, 32'h0);
      chk("rst s_wstrb", {28'b0, p_s_wstrb}, 32'h0);
      chk("rst s_resp_ready", {31'b0, p_s_resp_ready}, 32'h0);
      chk("rst m1_resp_valid", {31'b0, p_m1_resp_valid}, 32'h0);
      chk("rst m1_rdata", p_m1_rdata, 32'h0);
      chk("rst m1_err", {31'b0, p_m1_err}, 32'h0);
      chk("rst m0_resp_valid", {31'b0, p_m0_resp_valid}, 32'h0);
      next_cycle();
      drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
      #2;
      chk("post-rst m0_req_ready", {31'b0, p_m0_req_ready}, 32'h1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      #2;
      chk("post-rst s_req_valid", {31'b0, p_s_req_valid}, 32'h1);
      chk("post-rst s_addr", p_s_addr, A0);

      // Round-robin instance with both masters requesting continuously.
      drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      repeat (2) next_cycle();
      for (int k = 0; k < 4; k++) begin
         logic w;
         w = (k % 2 == 0);
         drive(0, 1, 1, 0, 0, 0, 0, 32'h0, 0);
         #2;
         chk($sformatf("rr%0d m0_req_ready", k), {31'b0, r_m0_req_ready}, {31'b0, ~w});
         chk($sformatf("rr%0d m1_req_ready", k), {31'b0, r_m1_req_ready}, {31'b0, w});
         next_cycle();
         drive(0, 1, 1, 1, 0, 0, 0, 32'h0, 0);
         #2;
         chk($sformatf("rr%0d s_addr", k), r_s_addr, w ? A1 : A0);
         next_cycle();
         drive(0, 1, 1, 0, 1, 1, 1, 32'h70 + k, 0);
         #2;
         chk($sformatf("rr%0d m0_resp_valid", k), {31'b0, r_m0_resp_valid}, {31'b0, ~w});
         chk($sformatf("rr%0d m1_resp_valid", k), {31'b0, r_m1_resp_valid}, {31'b0, w});
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_24080006_mem_arb.md
Name: ysyx_24080006_mem_arb

Overview:
Two-master, one-slave arbiter that shares the core's single memory port between instruction fetch (master 0, read-only) and load/store (master 1).
- Sits between the IFU/LSU request channels and the memory/bus bridge.
- Allows exactly one outstanding transaction; the owner is held from request acceptance until its response handshake completes.
- The selection policy is fixed-priority or round-robin, set by a parameter.

Parameters:
AW, 32, address width
DW, 32, data width (wstrb width is DW/8)
LSU_PRIO, 1, 1 = master 1 wins simultaneous requests; 0 = round-robin on simultaneous requests

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_req_valid  in  1  IFU request valid
m0_req_ready  out  1  IFU request accepted
m0_addr  in  AW  IFU fetch address
m0_resp_valid  out  1  IFU response valid
m0_resp_ready  in  1  IFU can take response
m0_rdata  out  DW  IFU read data
m0_err  out  1  IFU response error
m1_req_valid  in  1  LSU request valid
m1_req_ready  out  1  LSU request accepted
m1_addr  in  AW  LSU address
m1_we  in  1  LSU write enable
m1_wdata  in  DW  LSU write data
m1_wstrb  in  DW/8  LSU byte strobes
m1_resp_valid  out  1  LSU response valid
m1_resp_ready  in  1  LSU can take response
m1_rdata  out  DW  LSU read data
m1_err  out  1  LSU response error
s_req_valid  out  1  request to memory
s_req_ready  in  1  memory accepts request
s_addr  out  AW  registered address
s_we  out  1  registered write enable
s_wdata  out  DW  registered write data
s_wstrb  out  DW/8  registered strobes
s_resp_valid  in  1  memory response valid
s_resp_ready  out  1  arbiter can take response
s_rdata  in  DW  memory read data
s_err  in  1  memory response error

Behaviour:
- Reset applies synchronously on reset=1 at a clock edge, including mid-transaction:
  - State goes to IDLE; owner=0; last_grant=0.
  - The in-flight transaction is dropped; no response is ever delivered for it.
  - All s_* request registers are cleared to 0.
- Reset values of outputs: all *_ready, *_valid, *_err = 0; rdata = 0; s_addr/s_we/s_wdata/s_wstrb = 0.
- State machine:
  - IDLE → REQ on any accepted request.
  - REQ → RESP on s_req_valid && s_req_ready.
  - RESP → IDLE on the response handshake (s_resp_valid && owner resp_ready).
- Arbitration is evaluated in IDLE only:
  - One requester: that master wins.
  - Both requesting, LSU_PRIO=1: m1 wins.
  - Both requesting, LSU_PRIO=0: the master not equal to last_grant wins.
  - last_grant updates on every grant.
- In IDLE, the winner's req_ready is asserted combinationally; the loser's req_ready stays 0. In REQ and RESP, both req_ready = 0.
- On acceptance at edge N:
  - Capture addr/we/wdata/wstrb into the s_* registers; record the owner.
  - For m0: s_we=0, s_wdata=0, s_wstrb=0.
  - s_req_valid=1 from cycle N+1, held with stable payload until s_req_ready.
  - s_req_valid drops the cycle after the handshake.
- In RESP:
  - s_resp_ready = owner's resp_ready.
  - Owner's resp_valid = s_resp_valid; owner's rdata/err = s_rdata/s_err (combinational pass-through).
  - Non-owner resp_valid=0, rdata=0, err=0.
- Back-to-back: a new request may be accepted in the IDLE cycle that follows a response handshake. Minimum transaction occupancy is 3 cycles (IDLE, REQ, RESP).
- Preemption: a request raised while busy waits; there is no preemption. Masters must hold req_valid and payload until req_ready.
- s_resp_valid arriving in IDLE or REQ is ignored (s_resp_ready=0 there).
- s_err is forwarded unchanged; the arbiter takes no error recovery action.

Test Plan:
1. IFU read alone: m0_req_valid, m0_addr=0x8000_0000 → m0_req_ready in IDLE; s_req_valid next cycle with s_addr=0x8000_0000, s_we=0. Memory returns 0x0000_0413 → m0_resp_valid with m0_rdata=0x0000_0413; m1_resp_valid=0 throughout.
2. LSU write alone: addr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=4'b1111 → s_* carry exactly these values with s_we=1; response with s_err=1 → m1_err=1.
3. Simultaneous requests, LSU_PRIO=1, repeated 3 times → m1 granted each time; m0 granted only after m1_req_valid drops.
4. Simultaneous persistent requests, LSU_PRIO=0 → grant order alternates m1, m0, m1, m0 (last_grant=0 after reset).
5. Back-pressure: s_req_ready held low for 5 cycles → s_req_valid and s_addr stay stable. m1_resp_ready low for 3 cycles with s_resp_valid high → s_resp_ready low; state stays RESP.
6. Reset asserted in RESP with s_resp_valid=1 → next cycle all outputs are 0 and state is IDLE; a following m0 request is granted normally.
